// File: rtl/calc_pkg.sv
// calc_pkg: opcode constants, opcode width and FSM state encoding shared by
// the calculator top and its ALU.
`default_nettype none

package calc_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_CLR  = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
   localparam logic [OP_W-1:0] OP_AND  = 3'd3;
   localparam logic [OP_W-1:0] OP_OR   = 3'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_LOAD = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_alu.sv
// calc_alu: combinational accumulator ALU. Optional macro CALC_SATURATE_EN
// clamps signed-overflowing ADD/SUB results instead of wrapping.
`default_nettype none

module calc_alu
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_val,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, acc} + {1'b0, operand};
   assign diff = {1'b0, acc} - {1'b0, operand};

`ifdef CALC_SATURATE_EN
   // Overflow always moves away from the accumulator's sign, so its MSB picks the rail.
   logic [WIDTH-1:0] sat_val;
   assign sat_val = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif

   always_comb begin
      next_val = acc;
      carry    = 1'b0;
      ovf      = 1'b0;
      case (op)
         OP_CLR:  next_val = '0;
         OP_ADD: begin
            next_val = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            ovf      = (acc[WIDTH-1] == operand[WIDTH-1]) &&
                       (sum[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_SUB: begin
            next_val = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            ovf      = (acc[WIDTH-1] != operand[WIDTH-1]) &&
                       (diff[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_AND:  next_val = acc & operand;
         OP_OR:   next_val = acc | operand;
         OP_XOR:  next_val = acc ^ operand;
         OP_LOAD: next_val = operand;
         OP_PASS: next_val = operand;
         default: next_val = acc;
      endcase
`ifdef CALC_SATURATE_EN
      if (ovf) begin
         next_val = sat_val;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/calculadora_param.sv
// calculadora_param: accumulator calculator with IDLE/EXEC/HOLD valid-ready
// handshake. Optional macro CALC_SATURATE_EN selects saturating ADD/SUB.
`default_nettype none

module calculadora_param
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             zero
);

   state_t           state;
   state_t           state_nx;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] alu_val;
   logic             alu_carry;
   logic             alu_ovf;

   calc_alu #(.WIDTH(WIDTH)) u_alu (
      .op       (op_q),
      .acc      (acc),
      .operand  (opnd_q),
      .next_val (alu_val),
      .carry    (alu_carry),
      .ovf      (alu_ovf)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_EXEC;
         end
         ST_EXEC: state_nx = ST_HOLD;
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= OP_CLR;
         opnd_q <= '0;
         acc    <= '0;
         result <= '0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
      end else if (clr) begin
         acc    <= '0;
         result <= '0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (state == ST_IDLE && in_valid) begin
            op_q   <= op;
            opnd_q <= operand;
         end
         if (state == ST_EXEC) begin
            result <= alu_val;
            carry  <= alu_carry;
            ovf    <= alu_ovf;
            // PASS only forwards the operand; the accumulator keeps its value.
            if (op_q != OP_PASS) acc <= alu_val;
         end
      end
   end

   assign zero = (result == '0);

endmodule

`default_nettype wire

// File: tb/tb_calculadora_param.sv
// tb_calculadora_param: directed-vector bench for calculadora_param (WIDTH=8).
`default_nettype none

module tb_calculadora_param;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = 3'd0;
   logic [7:0] operand = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       carry;
   logic       ovf;
   logic       zero;

   int n_vec = 0;
   int n_err = 0;

   calculadora_param #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand   (operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and leave the block in HOLD with the result visible.
   task automatic run_cmd(input logic [2:0] o, input logic [7:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      op       = o;
      operand  = d;
      @(negedge clk);
      in_valid = 1'b0;
      check("exec_in_ready", in_ready, 0);
      check("exec_out_valid", out_valid, 0);
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [7:0] r,
                             input logic c, input logic v, input logic z);
      check({tag, "_result"}, result, r);
      check({tag, "_carry"}, carry, c);
      check({tag, "_ovf"}, ovf, v);
      check({tag, "_zero"}, zero, z);
   endtask

   initial begin
      #12;
      check("rst_result", result, 8'h00);
      check("rst_zero", zero, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      run_cmd(OP_ADD, 8'h05);  expect_res("add05", 8'h05, 0, 0, 0); ack();
      run_cmd(OP_SUB, 8'h07);  expect_res("sub07", 8'hFE, 1, 0, 0); ack();
      check("ack_in_ready", in_ready, 1);

      run_cmd(OP_LOAD, 8'h7F); expect_res("load7f", 8'h7F, 0, 0, 0); ack();
      run_cmd(OP_ADD, 8'h01);
`ifdef CALC_SATURATE_EN
      expect_res("ovf_add", 8'h7F, 0, 1, 0);
`else
      expect_res("ovf_add", 8'h80, 0, 1, 0);
`endif
      ack();

      // Backpressure: a pending request must not be taken while HOLD stalls.
      run_cmd(OP_LOAD, 8'h10); expect_res("load10", 8'h10, 0, 0, 0);
      in_valid = 1'b1;
      op       = OP_ADD;
      operand  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result", result, 8'h10);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      ack();
      check("bp_rel_in_ready", in_ready, 1);
      check("bp_rel_out_valid", out_valid, 0);

      run_cmd(OP_PASS, 8'h3C); expect_res("pass3c", 8'h3C, 0, 0, 0); ack();
      run_cmd(OP_ADD, 8'h01);  expect_res("add_after_pass", 8'h11, 0, 0, 0); ack();

      run_cmd(OP_XOR, 8'h1D);  expect_res("xor1d", 8'h0C, 0, 0, 0); ack();
      run_cmd(OP_OR, 8'h30);   expect_res("or30", 8'h3C, 0, 0, 0); ack();
      run_cmd(OP_AND, 8'hF0);  expect_res("andf0", 8'h30, 0, 0, 0); ack();
      run_cmd(OP_CLR, 8'hAA);  expect_res("clr_op", 8'h00, 0, 0, 1); ack();
      run_cmd(OP_SUB, 8'h01);  expect_res("sub_wrap", 8'hFF, 1, 0, 0); ack();
      run_cmd(OP_SUB, 8'h80);  expect_res("sub80", 8'h7F, 0, 0, 0); ack();

      // Synchronous clear while holding a result.
      run_cmd(OP_LOAD, 8'h22); expect_res("load22", 8'h22, 0, 0, 0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_out_valid", out_valid, 0);
      check("clr_result", result, 8'h00);
      check("clr_zero", zero, 1);
      check("clr_in_ready", in_ready, 1);
      run_cmd(OP_ADD, 8'h03);  expect_res("add_after_clr", 8'h03, 0, 0, 0); ack();

      // Asynchronous reset mid-operation discards the held result.
      run_cmd(OP_LOAD, 8'h44);
      #2 reset = 1'b1;
      #1;
      check("arst_result", result, 8'h00);
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_zero", zero, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      run_cmd(OP_ADD, 8'h09);  expect_res("add_after_rst", 8'h09, 0, 0, 0); ack();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
